// File: rtl/riscv_pkg.sv
// Shared types and constants for the 64-bit RISC-V core.
// Fetch state enum, PC step and base opcodes.
package riscv_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [63:0] PC_STEP = 64'd4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    HALT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } if_id_t;

endpackage

// File: rtl/pc_reg.sv
// 64-bit program counter with reset value, +4 step and load.
// A load in the same cycle as a step wins.
module pc_reg
  import riscv_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        load,
  input  logic [63:0] load_pc,
  output logic [63:0] pc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, imem request FSM and registered word to decode.
// Define FETCH_MISALIGN_CHECK_EN to trap misaligned redirects in HALT.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [63:0] redirect_target,
  output logic        misalign_err
);

  fetch_state_e state_q, state_d;
  if_id_t       id_q;
  logic [63:0]  pc;
  logic         pc_inc;
  logic         pc_load;
  logic         capture;
  logic         drop;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic         set_err;
  logic         err_q;
`endif

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (pc_inc),
    .load   (pc_load),
    .load_pc(redirect_target & ~64'h3),
    .pc     (pc)
  );

  always_comb begin
    state_d = state_q;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    capture = 1'b0;
    drop    = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    set_err = 1'b0;
`endif
    unique case (1'b1)
      state_q == IDLE: state_d = REQ;
      state_q == REQ: begin
        if (imem_ready) begin
          capture = 1'b1;
          pc_inc  = 1'b1;
          state_d = HOLD;
        end
      end
      state_q == HOLD: begin
        if (inst_ready) begin
          drop    = 1'b1;
          state_d = REQ;
        end
      end
      default: ;
    endcase
    // Redirect squashes any response or held word this cycle.
    if (redirect && state_q != HALT) begin
      capture = 1'b0;
      pc_inc  = 1'b0;
      drop    = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (|redirect_target[1:0]) begin
        set_err = 1'b1;
        state_d = HALT;
      end else begin
        pc_load = 1'b1;
        state_d = REQ;
      end
`else
      pc_load = 1'b1;
      state_d = REQ;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      id_q       <= '0;
      inst_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        id_q       <= '{inst: imem_rdata, pc: pc};
        inst_valid <= 1'b1;
      end else if (drop) begin
        inst_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (set_err) begin
      err_q <= 1'b1;
    end
  end

  assign misalign_err = err_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign imem_req  = (state_q == REQ);
  assign imem_addr = imem_req ? pc : 64'h0;
  assign inst      = id_q.inst;
  assign inst_pc   = id_q.pc;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the 64-bit RISC-V core.
- Holds the PC, requests 32-bit words from instruction memory and registers each fetched word with its PC.
- Presents the registered word, with a valid/ready handshake, to decode; the registered word drives immediateG.inst directly.
- Accepts a single redirect (branch/JAL target, computed as PC + immediateG.imm) from execute.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  input  1  core clock, all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- imem_req  output  1  fetch request, asserted only in state REQ.
- imem_addr  output  64  fetch address; equals pc while imem_req=1, else 0.
- imem_ready  input  1  memory returns imem_rdata this cycle; sampled only when imem_req=1.
- imem_rdata  input  32  fetched instruction word.
- inst  output  32  registered instruction, feeds immediateG and decode.
- inst_pc  output  64  PC of inst.
- inst_valid  output  1  inst/inst_pc hold a live instruction.
- inst_ready  input  1  decode consumes inst this cycle when inst_valid=1.
- redirect  input  1  load redirect_target into pc and flush.
- redirect_target  input  64  new PC.
- misalign_err  output  1  sticky misaligned-redirect flag; tied 0 unless the feature is compiled in.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, pc=RESET_PC, inst=32'h0, inst_pc=0, inst_valid=0, misalign_err=0. Reset overrides redirect and imem_ready.
- States: IDLE, REQ, HOLD (plus HALT with the feature compiled in).
- IDLE:
  - imem_req=0.
  - Unconditionally go to REQ next cycle, giving one bubble after reset.
- REQ:
  - imem_req=1, imem_addr=pc.
  - While imem_ready=0: stay in REQ, outputs unchanged; the memory may stall indefinitely.
  - On imem_ready=1 at an edge: inst<=imem_rdata, inst_pc<=pc, pc<=pc+4, inst_valid<=1, go to HOLD.
  - Latency: word visible on inst the cycle after imem_ready.
- HOLD:
  - imem_req=0. inst/inst_pc/inst_valid are held stable until inst_ready=1.
  - On inst_ready=1: inst_valid<=0, go to REQ.
  - inst keeps its last value; it is don't-care while invalid.
  - Peak throughput is one instruction per 2 cycles.
- Redirect has priority over every state transition except reset:
  - pc<=redirect_target, inst_valid<=0, next state REQ.
  - A response with imem_ready=1 in the same cycle is discarded; pc does not advance to +4.
  - A HOLD instruction is dropped even if inst_ready=1 in the same cycle.
- PC arithmetic is modulo 2^64: pc=64'hFFFF_FFFF_FFFF_FFFC advances to 64'h0.
- imem_ready outside REQ is ignored.
- Mid-operation reset: an outstanding request is abandoned; a response arriving in the reset cycle is ignored.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- Defined:
  - A redirect with redirect_target[1:0]!=0 sets misalign_err<=1, leaves pc unchanged and clears inst_valid.
  - It enters HALT: imem_req=0, all redirects ignored, exit only by reset.
- Undefined:
  - redirect_target[1:0] is forced to 2'b00 when loaded.
  - misalign_err is constant 0 and there is no HALT state.

Decomposition:
- Package riscv_pkg holds:
  - opcode constants OP_BRANCH=7'b1100011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_JAL=7'b1101111;
  - the fetch state enum (IDLE, REQ, HOLD, HALT);
  - PC_STEP=64'd4.
- Sub-module pc_reg: 64-bit PC register with reset value, increment-by-4 enable and redirect load. Redirect beats increment.
- The FSM and output registers stay in instruction_fetch.

Test Plan:
- Reset then run, RESET_PC=0, imem_ready=1 always, inst_ready=1 always, imem_rdata=32'h00A00093 -> inst_valid=0 for 2 cycles after rst_n rises; imem_addr sequence 0,4,8 on REQ cycles; inst_pc=0 then 4; inst=32'h00A00093.
- Backpressure: inst_ready=0 for 5 cycles in HOLD -> inst, inst_pc and inst_valid stable; imem_req=0 throughout; the next request goes to the next PC only after inst_ready=1.
- Memory stall: imem_ready=0 for 3 cycles in REQ -> imem_req=1 and imem_addr unchanged; pc advances only on the ready cycle.
- Redirect in REQ with imem_ready=1, target 64'h100 -> response dropped, inst_valid=0, next imem_addr=64'h100, then inst_pc=64'h100.
- Wrap: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> first inst_pc=64'hFFFF_FFFF_FFFF_FFFC, next imem_addr=0.
- Misaligned redirect to 64'h102:
  - with FETCH_MISALIGN_CHECK_EN: misalign_err=1, imem_req=0 until reset, cleared by rst_n=0;
  - without it: next imem_addr=64'h100, misalign_err=0.
